// File: rtl/secret_unpacker_pkg.sv
// Shared constants and state encoding for the secret-polynomial unpacker.
package secret_unpacker_pkg;

    // Coefficient width (log2 q) and packing geometry.
    localparam int COEF_W           = 13;
    localparam int SM_W             = 4;
    localparam int SAMPLES_PER_WORD = 16;
    localparam int WORD_W           = 64;
    localparam int LANE_W           = 16;
    localparam int LANES_PER_WORD   = 4;

    // Largest legal binomial magnitude; the sampler uses the same limit.
    localparam int MU_HALF          = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_LATCH = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/secret_unpacker_sm_to_coef.sv
// Combinational 4-bit sign-magnitude sample to CW-bit two's-complement
// coefficient (mod 2^CW). Flags magnitudes above MU_HALF and negative zero;
// the decoded value is produced regardless so the caller can still write it.
module sm_to_coef
    import secret_unpacker_pkg::*;
#(
    parameter int CW = secret_unpacker_pkg::COEF_W
) (
    input  logic [SM_W-1:0] sm_i,
    output logic [CW-1:0]   coef_o,
    output logic            illegal_o
);

    localparam logic [SM_W-2:0] MAG_LIMIT = (SM_W-1)'(MU_HALF);

    logic            sign;
    logic [SM_W-2:0] mag;
    logic [CW-1:0]   mag_ext;

    // Negative samples wrap to 2^CW - mag; negative zero lands on 0 naturally.
    always_comb begin
        sign      = sm_i[SM_W-1];
        mag       = sm_i[SM_W-2:0];
        mag_ext   = CW'(mag);
        coef_o    = sign ? ('0 - mag_ext) : mag_ext;
        illegal_o = (mag > MAG_LIMIT) || (sign && (mag == '0));
    end

endmodule

// File: rtl/secret_unpacker.sv
// Reads packed 4-bit sign-magnitude samples from the secret BRAM and writes
// them back as four 16-bit coefficient lanes per word into the multiplier
// coefficient BRAM. One RD cycle, then 5 cycles per input word (LATCH + 4 EMIT);
// the next word is prefetched during LATCH so it is ready at the next LATCH.
//
// Handshake: start is a single-cycle pulse honoured only in IDLE or DONE.
// The write port has no back-pressure: a write happens in every cycle wen is
// high, with wt_address/data_out valid in that same cycle.
module secret_unpacker
    import secret_unpacker_pkg::*;
#(
    parameter int NUM_WORDS = 48,
    parameter int ADDR_W    = 9,
    parameter int COEF_W    = secret_unpacker_pkg::COEF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_address,
    input  logic [63:0]       data_in,
    output logic [ADDR_W-1:0] wt_address,
    output logic [63:0]       data_out,
    output logic              wen,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state_o
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wt_addr_q, wt_addr_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [1:0]        lane_q, lane_d;
    logic [63:0]       hold_q, hold_d;
    logic              err_q, err_d;

    logic [LANE_W-1:0] group;
    logic [3:0]        lane_illegal;
    logic [63:0]       packed_lanes;

    // The four samples feeding the current output word sit in one 16-bit slice.
    assign group = hold_q[{lane_q, 4'b0000} +: LANE_W];

    for (genvar k = 0; k < LANES_PER_WORD; k++) begin : g_lane
        logic [COEF_W-1:0] coef;
        sm_to_coef #(.CW(COEF_W)) u_dec (
            .sm_i      (group[SM_W*k +: SM_W]),
            .coef_o    (coef),
            .illegal_o (lane_illegal[k])
        );
        assign packed_lanes[LANE_W*k +: LANE_W] = {{(LANE_W-COEF_W){1'b0}}, coef};
    end

    // State and datapath registers; synchronous reset aborts any run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= '0;
            wt_addr_q <= '0;
            word_q    <= '0;
            lane_q    <= '0;
            hold_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            wt_addr_q <= wt_addr_d;
            word_q    <= word_d;
            lane_q    <= lane_d;
            hold_q    <= hold_d;
            err_q     <= err_d;
        end
    end

    // Next-state and datapath updates for the RD/LATCH/EMIT sequence.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        wt_addr_d = wt_addr_q;
        word_d    = word_q;
        lane_d    = lane_q;
        hold_d    = hold_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RD;
                    rd_addr_d = '0;
                    wt_addr_d = '0;
                    word_d    = '0;
                    lane_d    = '0;
                    err_d     = 1'b0;
                end
            end
            ST_RD: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                hold_d    = data_in;
                rd_addr_d = rd_addr_q + ADDR_W'(1);
                lane_d    = '0;
                state_d   = ST_EMIT;
            end
            ST_EMIT: begin
                wt_addr_d = wt_addr_q + ADDR_W'(1);
                lane_d    = lane_q + 2'd1;
                if (|lane_illegal) begin
                    err_d = 1'b1;
                end
                if (lane_q == 2'd3) begin
                    if (word_q == LAST_WORD) begin
                        state_d = ST_DONE;
                    end else begin
                        word_d  = word_q + ADDR_W'(1);
                        state_d = ST_LATCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs; the write is suppressed in a reset cycle even mid-EMIT.
    always_comb begin
        wen         = (state_q == ST_EMIT) && !rst;
        data_out    = (state_q == ST_EMIT) ? packed_lanes : 64'd0;
        busy        = (state_q == ST_RD) || (state_q == ST_LATCH) || (state_q == ST_EMIT);
        done        = (state_q == ST_DONE);
        err         = err_q;
        rd_address  = rd_addr_q;
        wt_address  = wt_addr_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_secret_unpacker.sv
// Bench for secret_unpacker: a NUM_WORDS=1 instance for directed single-word
// vectors and a default (48-word) instance for full runs, abort and restart.
module tb_secret_unpacker;
    import secret_unpacker_pkg::*;

    localparam int NW   = 48;
    localparam int AW   = 9;
    localparam int SB_W = AW + 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start  = 1'b0;
    logic          start1 = 1'b0;
    logic [AW-1:0] rd_address, wt_address, rd_address1, wt_address1;
    logic [63:0]   data_in = 64'd0, data_in1 = 64'd0;
    logic [63:0]   data_out, data_out1;
    logic          wen, busy, done, err;
    logic          wen1, busy1, done1, err1;
    logic [2:0]    dbg_state, dbg_state1;

    logic [63:0] mem  [0:511];
    logic [63:0] mem1 [0:511];

    secret_unpacker #(.NUM_WORDS(NW), .ADDR_W(AW), .COEF_W(13)) dut (
        .clk(clk), .rst(rst), .start(start), .rd_address(rd_address),
        .data_in(data_in), .wt_address(wt_address), .data_out(data_out),
        .wen(wen), .busy(busy), .done(done), .err(err), .dbg_state_o(dbg_state)
    );

    secret_unpacker #(.NUM_WORDS(1), .ADDR_W(AW), .COEF_W(13)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .rd_address(rd_address1),
        .data_in(data_in1), .wt_address(wt_address1), .data_out(data_out1),
        .wen(wen1), .busy(busy1), .done(done1), .err(err1), .dbg_state_o(dbg_state1)
    );

    // BRAM models with one-cycle read latency.
    always @(posedge clk) begin
        data_in  <= mem[rd_address];
        data_in1 <= mem1[rd_address1];
    end

    // ---------------- scoreboard ----------------
    logic [SB_W-1:0] exp_q[$];
    logic [SB_W-1:0] exp1_q[$];
    logic [SB_W-1:0] e_big, e_one;
    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int wr1_cnt = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_lane(input logic [3:0] s);
        int m;
        m = int'(s[2:0]);
        if (s[3]) return 16'((8192 - m) % 8192);
        return 16'(m);
    endfunction

    function automatic logic [63:0] ref_out(input logic [63:0] w, input int j);
        logic [63:0] r;
        r = 64'd0;
        for (int k = 0; k < 4; k++) r[16*k +: 16] = ref_lane(w[16*j + 4*k +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] pat(input int i);
        return 64'(i) * 64'h0101_0101_0101_0101;
    endfunction

    // Monitors: every write must match the head of its expected queue.
    always @(negedge clk) begin
        if (wen === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL big_extra_write: got addr %0d data %0h, required no write", wt_address, data_out);
            end else begin
                e_big = exp_q.pop_front();
                check("big_wr_addr", 64'(wt_address), 64'(e_big[SB_W-1:64]));
                check("big_wr_data", data_out, e_big[63:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (wen1 === 1'b1) begin
            wr1_cnt++;
            if (exp1_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL one_extra_write: got addr %0d data %0h, required no write", wt_address1, data_out1);
            end else begin
                e_one = exp1_q.pop_front();
                check("one_wr_addr", 64'(wt_address1), 64'(e_one[SB_W-1:64]));
                check("one_wr_data", data_out1, e_one[63:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Single-word run on dut1; err_rise = first cycle err is expected high (0 = never).
    task automatic run_small(input logic [63:0] w, input logic [63:0] e0, input logic [63:0] e1,
                             input logic [63:0] e2, input logic [63:0] e3, input int err_rise);
        int n0;
        mem1[0] = w;
        exp1_q.push_back({AW'(0), e0});
        exp1_q.push_back({AW'(1), e1});
        exp1_q.push_back({AW'(2), e2});
        exp1_q.push_back({AW'(3), e3});
        n0 = wr1_cnt;
        cyc = 0;
        start1 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            start1 = 1'b0;
            check("one_err", 64'(err1), 64'((err_rise != 0) && (c >= err_rise)));
            check("one_done", 64'(done1), 64'(c >= 7));
        end
        check("one_wt_end", 64'(wt_address1), 64'd4);
        check("one_wr_count", 64'(wr1_cnt - n0), 64'd4);
        check("one_queue_empty", 64'(exp1_q.size()), 64'd0);
    endtask

    task automatic push_full();
        for (int i = 0; i < NW; i++)
            for (int j = 0; j < 4; j++)
                exp_q.push_back({AW'(4*i + j), ref_out(pat(i), j)});
    endtask

    // Full 48-word run; word 5 holds sample 0101 in lane group 0 -> err from cycle 29.
    task automatic run_full(input bit mid_start);
        int n0;
        push_full();
        n0 = wr_cnt;
        cyc = 0;
        start = 1'b1;
        for (int c = 1; c <= 242; c++) begin
            next_cycle();
            start = 1'b0;
            check("big_err", 64'(err), 64'(c >= 29));
            check("big_done", 64'(done), 64'(c >= 242));
            check("big_busy", 64'(busy), 64'(c < 242));
            if (mid_start && c == 100) start = 1'b1;
        end
        check("big_state_done", 64'(dbg_state), 64'(ST_DONE));
        check("big_rd_end", 64'(rd_address), 64'd48);
        check("big_wt_end", 64'(wt_address), 64'd192);
        check("big_wr_count", 64'(wr_cnt - n0), 64'd192);
        check("big_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Run aborted by reset during EMIT of word 10 (lane 1, cycle 54).
    task automatic run_abort();
        int n0;
        push_full();
        n0 = wr_cnt;
        cyc = 0;
        start = 1'b1;
        for (int c = 1; c <= 54; c++) begin
            next_cycle();
            start = 1'b0;
            check("abort_err", 64'(err), 64'(c >= 29));
            check("abort_busy", 64'(busy), 64'd1);
            if (c == 54) rst = 1'b1;
        end
        next_cycle();
        rst = 1'b0;
        check("abort_wen", 64'(wen), 64'd0);
        check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
        check("abort_rd", 64'(rd_address), 64'd0);
        check("abort_wt", 64'(wt_address), 64'd0);
        check("abort_err_clr", 64'(err), 64'd0);
        check("abort_busy_clr", 64'(busy), 64'd0);
        check("abort_wr_count", 64'(wr_cnt - n0), 64'd41);
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i]  = pat(i);
            mem1[i] = 64'd0;
        end
        rst = 1'b1;
        repeat (3) next_cycle();
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        check("rst_rd", 64'(rd_address), 64'd0);
        check("rst_wt", 64'(wt_address), 64'd0);
        check("rst_dout", data_out, 64'd0);
        check("rst_flags", {60'd0, wen, err, busy, done}, 64'd0);
        check("rst1_state", 64'(dbg_state1), 64'(ST_IDLE));
        check("rst1_flags", {60'd0, wen1, err1, busy1, done1}, 64'd0);
        rst = 1'b0;
        next_cycle();

        // All-zero word.
        run_small(64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 0);
        // -1, +4, -4, +3 in samples 0..3.
        run_small(64'h0000_0000_0000_3C49, 64'h0003_1FFC_0004_1FFF, 64'h0, 64'h0, 64'h0, 0);
        // Negative zero at sample 6 (lane group 1, written in cycle 4).
        run_small(64'h0000_0000_0800_0000, 64'h0, 64'h0, 64'h0, 64'h0, 5);
        // Magnitude 5 at sample 13 (lane group 3, lane 1, written in cycle 6).
        run_small(64'h0050_0000_0000_0000, 64'h0, 64'h0, 64'h0, 64'h0000_0000_0005_0000, 7);

        run_full(1'b0);
        run_abort();
        run_full(1'b1);
        run_full(1'b0);

        repeat (2) next_cycle();
        check("final_queue_big", 64'(exp_q.size()), 64'd0);
        check("final_queue_one", 64'(exp1_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
